// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin CPU/debug arbiter for the single LC-3 memory port with access watchdog
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    input  logic              i_CPU_Req,
    input  logic              i_CPU_WE,
    input  logic [ADDR_W-1:0] i_CPU_Addr,
    input  logic [DATA_W-1:0] i_CPU_WData,
    output logic [DATA_W-1:0] o_CPU_RData,
    output logic              o_CPU_Ready,
    input  logic              i_DBG_Req,
    input  logic              i_DBG_WE,
    input  logic [ADDR_W-1:0] i_DBG_Addr,
    input  logic [DATA_W-1:0] i_DBG_WData,
    output logic [DATA_W-1:0] o_DBG_RData,
    output logic              o_DBG_Ready,
    output logic              o_Err,
    output logic              o_MEM_En,
    output logic              o_MEM_WE,
    output logic [ADDR_W-1:0] o_MEM_Addr,
    output logic [DATA_W-1:0] o_MEM_WData,
    input  logic [DATA_W-1:0] i_MEM_RData,
    input  logic              i_MEM_Ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dbg_ready_q, dbg_ready_d;

    logic              grant_dbg;
    logic              finish;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        cpu_ready_d  = 1'b0;
        dbg_ready_d  = 1'b0;
        grant_dbg    = 1'b0;
        finish       = 1'b0;
        resp_data    = '0;

        case (state_q)
            S_IDLE: begin
                if (i_CPU_Req || i_DBG_Req) begin
                    // On a tie the requester that did not win last time gets the port
                    grant_dbg    = i_DBG_Req && (!i_CPU_Req || last_grant_q == OWN_CPU);
                    owner_d      = grant_dbg;
                    last_grant_d = grant_dbg;
                    mem_we_d     = grant_dbg ? i_DBG_WE    : i_CPU_WE;
                    mem_addr_d   = grant_dbg ? i_DBG_Addr  : i_CPU_Addr;
                    mem_wdata_d  = grant_dbg ? i_DBG_WData : i_CPU_WData;
                    cnt_d        = '0;
                    mem_en_d     = 1'b1;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                if (i_MEM_Ready) begin
                    finish    = 1'b1;
                    resp_data = mem_we_q ? '0 : i_MEM_RData;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    finish    = 1'b1;
                    resp_data = '1;
                    err_d     = 1'b1;
                end else begin
                    mem_en_d  = 1'b1;
                end
                if (finish) begin
                    state_d = S_RESP;
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = resp_data;
                        cpu_ready_d = 1'b1;
                    end else begin
                        dbg_rdata_d = resp_data;
                        dbg_ready_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_DBG;
            owner_q      <= OWN_CPU;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            dbg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            dbg_ready_q  <= dbg_ready_d;
        end
    end

    assign o_CPU_RData = cpu_rdata_q;
    assign o_CPU_Ready = cpu_ready_q;
    assign o_DBG_RData = dbg_rdata_q;
    assign o_DBG_Ready = dbg_ready_q;
    assign o_Err       = err_q;
    assign o_MEM_En    = mem_en_q;
    assign o_MEM_WE    = mem_we_q;
    assign o_MEM_Addr  = mem_addr_q;
    assign o_MEM_WData = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic        cpu_ready, dbg_ready, err, mem_en, mem_we;

    int n_pass  = 0;
    int n_total = 0;
    int en_cycles;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .i_CLK       (clk),
        .i_Reset     (rst_n),
        .i_CPU_Req   (cpu_req),
        .i_CPU_WE    (cpu_we),
        .i_CPU_Addr  (cpu_addr),
        .i_CPU_WData (cpu_wdata),
        .o_CPU_RData (cpu_rdata),
        .o_CPU_Ready (cpu_ready),
        .i_DBG_Req   (dbg_req),
        .i_DBG_WE    (dbg_we),
        .i_DBG_Addr  (dbg_addr),
        .i_DBG_WData (dbg_wdata),
        .o_DBG_RData (dbg_rdata),
        .o_DBG_Ready (dbg_ready),
        .o_Err       (err),
        .o_MEM_En    (mem_en),
        .o_MEM_WE    (mem_we),
        .o_MEM_Addr  (mem_addr),
        .o_MEM_WData (mem_wdata),
        .i_MEM_RData (mem_rdata),
        .i_MEM_Ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        step();
        step();
        check("reset_outputs",
              {cpu_rdata, dbg_rdata, mem_addr, mem_wdata, cpu_ready, dbg_ready, err, mem_en, mem_we},
              '0);

        // CPU read of 0x3000, memory answers on the second ACCESS cycle
        rst_n = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        step();
        check("t1_acc1", {mem_en, mem_we, mem_addr, cpu_ready}, {1'b1, 1'b0, 16'h3000, 1'b0});
        step();
        check("t1_acc2", {mem_en, cpu_ready}, {1'b1, 1'b0});
        mem_ready = 1; mem_rdata = 16'h1234;
        step();
        check("t1_ready", {cpu_ready, cpu_rdata, dbg_ready, mem_en, err},
              {1'b1, 16'h1234, 1'b0, 1'b0, 1'b0});
        cpu_req = 0;
        step();
        check("t1_after", {cpu_ready, dbg_ready, mem_en, cpu_rdata}, {1'b0, 1'b0, 1'b0, 16'h1234});

        // DBG write, memory ready immediately (k=1)
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0200; dbg_wdata = 16'hBEEF;
        step();
        check("t2_acc", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0200, 16'hBEEF});
        step();
        check("t2_ready", {dbg_ready, err, cpu_ready, dbg_rdata}, {1'b1, 1'b0, 1'b0, 16'h0000});
        dbg_req = 0; mem_ready = 0;
        step();
        check("t2_after", {dbg_ready, mem_en}, {1'b0, 1'b0});

        // Both requesting from reset: CPU, DBG, CPU, DBG
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1000;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h2000;
        mem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 16'h0A00 + 16'(i);
            step();
            check($sformatf("t3_addr%0d", i), {mem_en, mem_addr},
                  {1'b1, (i % 2 == 0) ? 16'h1000 : 16'h2000});
            step();
            if (i % 2 == 0)
                check($sformatf("t3_cpu%0d", i), {cpu_ready, dbg_ready, cpu_rdata},
                      {1'b1, 1'b0, 16'h0A00 + 16'(i)});
            else
                check($sformatf("t3_dbg%0d", i), {cpu_ready, dbg_ready, dbg_rdata},
                      {1'b0, 1'b1, 16'h0A00 + 16'(i)});
            if (i == 3) begin
                cpu_req = 0; dbg_req = 0;
            end
            step();
        end
        mem_ready = 0;

        // Watchdog: memory never answers
        cpu_req = 1; cpu_addr = 16'h4000;
        step();
        en_cycles = 0;
        for (int c = 0; c < 40 && mem_en; c++) begin
            en_cycles++;
            step();
        end
        check("t4_en_cycles", 64'(en_cycles), 64'd15);
        check("t4_ready", {cpu_ready, err, cpu_rdata, dbg_ready}, {1'b1, 1'b1, 16'hFFFF, 1'b0});
        cpu_req = 0;
        step();
        check("t4_after", {cpu_ready, err, mem_en}, {1'b0, 1'b0, 1'b0});

        // Memory ready on the final timeout cycle
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0300;
        step();
        for (int c = 0; c < 14; c++) step();
        check("t5_last_cycle", {mem_en, dbg_ready}, {1'b1, 1'b0});
        mem_ready = 1; mem_rdata = 16'h7777;
        step();
        check("t5_ready", {dbg_ready, err, dbg_rdata}, {1'b1, 1'b0, 16'h7777});
        dbg_req = 0; mem_ready = 0;
        step();

        // Async reset in the middle of an access
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h5000; cpu_wdata = 16'hAAAA;
        step();
        check("t6_acc", {mem_en, mem_addr}, {1'b1, 16'h5000});
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_zero",
              {cpu_rdata, dbg_rdata, mem_addr, mem_wdata, cpu_ready, dbg_ready, err, mem_en, mem_we},
              '0);
        cpu_req = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0400;
        mem_ready = 1; mem_rdata = 16'h4242;
        step();
        check("t6_no_ready", {cpu_ready, dbg_ready}, {1'b0, 1'b0});
        rst_n = 1'b1;
        step();
        check("t6_grant", {mem_en, mem_addr, mem_we}, {1'b1, 16'h0400, 1'b0});
        step();
        check("t6_ready", {dbg_ready, cpu_ready, dbg_rdata, err}, {1'b1, 1'b0, 16'h4242, 1'b0});
        dbg_req = 0; mem_ready = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
